addsubmax_pipe: RTL and testbench

//  Parametrised, pipelined add/sub/max unit for the square-root datapath and

---
 rtl/addsubmax_pkg.sv | 16 +
 rtl/addsubmax_core.sv | 63 ++++++
 rtl/addsubmax_pipe.sv | 97 +++++++++
 tb/tb_addsubmax_pipe.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/addsubmax_pkg.sv
// Shared encodings for the add/sub/max pipeline: op codes and flag bit positions.
package addsubmax_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_MAX  = 2'b11
  } op_e;

  localparam int FLAG_CARRY = 0;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_W     = 3;

endpackage

// File: rtl/addsubmax_core.sv
// Combinational add/sub/max datapath with carry/overflow detection and optional clamping.
module addsubmax_core
  import addsubmax_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] r,
  output logic             carry,
  output logic             ovf
);

  logic        [WIDTH:0]   sum;
  logic        [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic                    a_ge_b;
  logic                    add_sovf;
  logic                    sub_sovf;

  function automatic logic [WIDTH-1:0] sat_value(input logic is_sub, input logic sign_a);
    if (SIGNED)
      return sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return is_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
  endfunction

  // Subtraction as a + ~b + 1 so the top bit is a "no borrow" indicator.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign a_s  = a;
  assign b_s  = b;

  assign a_ge_b   = SIGNED ? (a_s >= b_s) : (a >= b);
  assign add_sovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign sub_sovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    r     = a;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        r     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf   = SIGNED ? add_sovf : sum[WIDTH];
      end
      OP_SUB: begin
        r     = diff[WIDTH-1:0];
        carry = diff[WIDTH];
        ovf   = SIGNED ? sub_sovf : !diff[WIDTH];
      end
      OP_MAX:  r = a_ge_b ? a : b;
      default: r = a;
    endcase
    if (SATURATE && ovf)
      r = sat_value(op == OP_SUB, a[WIDTH-1]);
  end

endmodule

// File: rtl/addsubmax_pipe.sv
// Two-stage add/sub/max unit with valid/ready on both sides, one op per cycle.
module addsubmax_pipe
  import addsubmax_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] m,
  output logic             carry,
  output logic             ovf,
  output logic             zero
);

  logic              vld_p1;
  logic              vld_p2;
  logic [WIDTH-1:0]  a_p1;
  logic [WIDTH-1:0]  b_p1;
  logic [1:0]        op_p1;
  logic [WIDTH-1:0]  r_p1;
  logic              carry_p1;
  logic              ovf_p1;
  logic [FLAG_W-1:0] flags_p1;
  logic [WIDTH-1:0]  m_p2;
  logic [FLAG_W-1:0] flags_p2;
  logic              adv1;
  logic              adv2;

  // Stall chain is combinational from out_ready so a full pipe still moves every cycle.
  assign adv2     = !vld_p2 || out_ready;
  assign adv1     = !vld_p1 || adv2;
  assign in_ready = adv1;

  // Stage 1: operand capture
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      a_p1  <= a;
      b_p1  <= b;
      op_p1 <= op;
    end
  end

  addsubmax_core #(
    .WIDTH    (WIDTH),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_core (
    .a     (a_p1),
    .b     (b_p1),
    .op    (op_p1),
    .r     (r_p1),
    .carry (carry_p1),
    .ovf   (ovf_p1)
  );

  always_comb begin
    flags_p1             = '0;
    flags_p1[FLAG_CARRY] = carry_p1;
    flags_p1[FLAG_OVF]   = ovf_p1;
    flags_p1[FLAG_ZERO]  = (r_p1 == '0);
  end

  // Stage 2: result and flags; cleared on reset so nothing stale is ever presented
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      m_p2     <= '0;
      flags_p2 <= '0;
    end else begin
      if (adv1)
        vld_p1 <= in_valid;
      if (adv2)
        vld_p2 <= vld_p1;
      if (adv2 && vld_p1) begin
        m_p2     <= r_p1;
        flags_p2 <= flags_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign m         = m_p2;
  assign carry     = flags_p2[FLAG_CARRY];
  assign ovf       = flags_p2[FLAG_OVF];
  assign zero      = flags_p2[FLAG_ZERO];

endmodule

// File: tb/tb_addsubmax_pipe.sv
// Scoreboard bench: an unsigned/wrapping and a signed/saturating instance share one stimulus stream.
module tb_addsubmax_pipe;

  typedef struct packed {
    logic [15:0] m;
    logic        carry;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct packed {
    res_t        r0;
    res_t        r1;
    logic [31:0] acc;
    logic        lat;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;
  logic        in_ready0, in_ready1;
  logic        out_valid0, out_valid1;
  logic [15:0] m0, m1;
  logic        c0, c1, o0, o1, z0, z1;

  int          checks = 0;
  int          errors = 0;
  int          n_out = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_out_cyc = 0;
  item_t       sb[$];

  addsubmax_pipe #(.WIDTH(16), .SIGNED(1'b0), .SATURATE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .op(op), .out_valid(out_valid0), .out_ready(out_ready),
    .m(m0), .carry(c0), .ovf(o0), .zero(z0)
  );

  addsubmax_pipe #(.WIDTH(16), .SIGNED(1'b1), .SATURATE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .op(op), .out_valid(out_valid1), .out_ready(out_ready),
    .m(m1), .carry(c1), .ovf(o1), .zero(z1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_res(input string tag, input logic [15:0] mm, input logic cc,
                           input logic oo, input logic zz, input res_t e);
    check({tag, "_m"}, 32'(mm), 32'(e.m));
    check({tag, "_carry"}, 32'(cc), 32'(e.carry));
    check({tag, "_ovf"}, 32'(oo), 32'(e.ovf));
    check({tag, "_zero"}, 32'(zz), 32'(e.zero));
  endtask

  function automatic res_t R(input logic [15:0] mm, input logic cc, input logic oo, input logic zz);
    res_t r;
    r.m = mm; r.carry = cc; r.ovf = oo; r.zero = zz;
    return r;
  endfunction

  // Independent reference: integer arithmetic, range checks for signed overflow.
  function automatic res_t model(input logic [15:0] ai, input logic [15:0] bi,
                                 input logic [1:0] opi, input bit sgn, input bit sat);
    res_t r;
    int ua = ai;
    int ub = bi;
    int sa = $signed(ai);
    int sb2 = $signed(bi);
    int t;
    r = '0;
    case (opi)
      2'd1: begin
        t = ua + ub;
        r.carry = (t > 65535);
        r.m = t[15:0];
        r.ovf = sgn ? ((sa + sb2) > 32767 || (sa + sb2) < -32768) : r.carry;
      end
      2'd2: begin
        r.carry = (ua >= ub);
        r.m = 16'(ua - ub);
        r.ovf = sgn ? ((sa - sb2) > 32767 || (sa - sb2) < -32768) : !r.carry;
      end
      2'd3: r.m = sgn ? ((sa >= sb2) ? ai : bi) : ((ua >= ub) ? ai : bi);
      default: r.m = ai;
    endcase
    if (sat && r.ovf)
      r.m = sgn ? (ai[15] ? 16'h8000 : 16'h7FFF) : ((opi == 2'd1) ? 16'hFFFF : 16'h0000);
    r.zero = (r.m == 16'h0000);
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the op is accepted.
  task automatic send(input logic [15:0] ai, input logic [15:0] bi, input logic [1:0] opi,
                      input res_t e0, input res_t e1, input logic lat);
    item_t it;
    bit    done;
    a = ai; b = bi; op = opi; in_valid = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      #4;
      if (in_ready0) begin
        it.r0 = e0; it.r1 = e1; it.acc = cyc; it.lat = lat;
        sb.push_back(it);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL accept_timeout: op %0d not accepted within 50 cycles", opi);
    end
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [15:0] ai, input logic [15:0] bi, input logic [1:0] opi);
    send(ai, bi, opi, model(ai, bi, opi, 1'b0, 1'b0), model(ai, bi, opi, 1'b1, 1'b1), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    #6;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    item_t it;
    #4;
    if (rst_n === 1'b1 && out_valid0 === 1'b1 && out_ready === 1'b1) begin
      n_out++;
      last_out_cyc = cyc;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_output: m0=0x%0h m1=0x%0h with empty scoreboard", m0, m1);
      end else begin
        it = sb.pop_front();
        check("out_valid1", 32'(out_valid1), 32'd1);
        check_res("u", m0, c0, o0, z0, it.r0);
        check_res("s", m1, c1, o1, z1, it.r1);
        if (it.lat) check("latency", cyc - it.acc, 32'd2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] m_hold;
    logic [31:0] c_start;
    int          base;

    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h0001; op = 2'd1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    #4;
    check("rst_out_valid0", 32'(out_valid0), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check_res("rst_u", m0, c0, o0, z0, R(16'h0000, 1'b0, 1'b0, 1'b0));
    check_res("rst_s", m1, c1, o1, z1, R(16'h0000, 1'b0, 1'b0, 1'b0));
    check("rst_in_ready0", 32'(in_ready0), 32'd1);
    check("rst_in_ready1", 32'(in_ready1), 32'd1);
    @(negedge clk);

    // Directed vectors: expected for unsigned/wrap (e0) and signed/saturate (e1).
    send(16'hFFFF, 16'h0001, 2'd1, R(16'h0000, 1, 1, 1), R(16'h0000, 1, 0, 1), 1'b1);
    send(16'h0003, 16'h0005, 2'd2, R(16'hFFFE, 0, 1, 0), R(16'hFFFE, 0, 0, 0), 1'b0);
    send(16'h8000, 16'h7FFF, 2'd3, R(16'h8000, 0, 0, 0), R(16'h7FFF, 0, 0, 0), 1'b0);
    send(16'h7FFF, 16'h0001, 2'd1, R(16'h8000, 0, 0, 0), R(16'h7FFF, 0, 1, 0), 1'b0);
    send(16'h8000, 16'h0001, 2'd2, R(16'h7FFF, 1, 0, 0), R(16'h8000, 1, 1, 0), 1'b0);
    send(16'h8000, 16'hFFFF, 2'd1, R(16'h7FFF, 1, 1, 0), R(16'h8000, 1, 1, 0), 1'b0);
    send(16'h0005, 16'h0005, 2'd2, R(16'h0000, 1, 0, 1), R(16'h0000, 1, 0, 1), 1'b0);
    send(16'h0005, 16'h0005, 2'd3, R(16'h0005, 0, 0, 0), R(16'h0005, 0, 0, 0), 1'b0);
    send(16'h1234, 16'h5678, 2'd0, R(16'h1234, 0, 0, 0), R(16'h1234, 0, 0, 0), 1'b0);
    send(16'h0000, 16'hFFFF, 2'd0, R(16'h0000, 0, 0, 1), R(16'h0000, 0, 0, 1), 1'b0);
    drain();

    // Back-pressure: pipe fills, input stalls, held output stays put.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0002, 2'd1, R(16'h0003, 0, 0, 0), R(16'h0003, 0, 0, 0), 1'b0);
        send(16'h0010, 16'h0003, 2'd2, R(16'h000D, 1, 0, 0), R(16'h000D, 1, 0, 0), 1'b0);
        send(16'h0003, 16'h0009, 2'd3, R(16'h0009, 0, 0, 0), R(16'h0009, 0, 0, 0), 1'b0);
        send(16'h00AA, 16'h0000, 2'd0, R(16'h00AA, 0, 0, 0), R(16'h00AA, 0, 0, 0), 1'b0);
      end
      begin
        repeat (2) @(negedge clk);
        #4;
        check("bp_in_ready0", 32'(in_ready0), 32'd0);
        check("bp_in_ready1", 32'(in_ready1), 32'd0);
        check("bp_out_valid", 32'(out_valid0), 32'd1);
        m_hold = m0;
        check("bp_head_m", 32'(m_hold), 32'h0003);
        @(negedge clk);
        #4;
        check("bp_m_stable", 32'(m0), 32'(m_hold));
        check("bp_valid_held", 32'(out_valid0), 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: 100 back-to-back random ops must stream at one result per cycle.
    @(negedge clk);
    c_start = cyc;
    base = n_out;
    for (int i = 0; i < 100; i++)
      sendm(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 2'($urandom_range(0, 3)));
    drain();
    check("thru_count", 32'(n_out - base), 32'd100);
    check("thru_last_cycle", last_out_cyc, c_start + 32'd101);

    // Reset with two ops in flight: both must be discarded.
    @(negedge clk);
    out_ready = 1'b0;
    sendm(16'h4321, 16'h1111, 2'd1);
    sendm(16'h0002, 16'h0007, 2'd2);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #4;
    check("mid_rst_out_valid0", 32'(out_valid0), 32'd0);
    check("mid_rst_out_valid1", 32'(out_valid1), 32'd0);
    check("mid_rst_m0", 32'(m0), 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    base = n_out;
    repeat (6) @(negedge clk);
    check("mid_rst_no_stale", 32'(n_out - base), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
